// File: rtl/s_check.sv
// Read-back checker for the 256-byte S memory: scans every address once and reports
// identity, permutation and XOR-checksum results.
module s_check (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] addr,
  output logic       wren,
  input  logic [7:0] rddata,
  output logic       res_valid,
  output logic       is_ident,
  output logic       is_perm,
  output logic [7:0] bad_addr,
  output logic [7:0] xor_sum
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]   state_q;
  logic [255:0] seen_q, seen_d;
  logic [7:0]   xor_q, xor_d;
  logic         dup_q, dup_d;
  logic         found_q, found_d;
  logic [7:0]   bad_q, bad_d;
  logic         cap_valid_q;
  logic [7:0]   cap_addr_q;

  assign wren = 1'b0;

  // Fold the sample tagged by cap_addr into the running results.
  always_comb begin
    seen_d  = seen_q;
    xor_d   = xor_q;
    dup_d   = dup_q;
    found_d = found_q;
    bad_d   = bad_q;
    if (cap_valid_q) begin
      xor_d = xor_q ^ rddata;
      if (seen_q[rddata]) dup_d = 1'b1;
      seen_d[rddata] = 1'b1;
      if ((rddata != cap_addr_q) && !found_q) begin
        found_d = 1'b1;
        bad_d   = cap_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rdy         <= 1'b1;
      addr        <= 8'd0;
      res_valid   <= 1'b0;
      is_ident    <= 1'b0;
      is_perm     <= 1'b0;
      bad_addr    <= 8'd0;
      xor_sum     <= 8'd0;
      seen_q      <= '0;
      xor_q       <= 8'd0;
      dup_q       <= 1'b0;
      found_q     <= 1'b0;
      bad_q       <= 8'd0;
      cap_valid_q <= 1'b0;
      cap_addr_q  <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) begin
            state_q     <= StScan;
            rdy         <= 1'b0;
            addr        <= 8'd0;
            res_valid   <= 1'b0;
            seen_q      <= '0;
            xor_q       <= 8'd0;
            dup_q       <= 1'b0;
            found_q     <= 1'b0;
            bad_q       <= 8'd0;
            cap_valid_q <= 1'b0;
          end
        end
        StScan: begin
          seen_q      <= seen_d;
          xor_q       <= xor_d;
          dup_q       <= dup_d;
          found_q     <= found_d;
          bad_q       <= bad_d;
          cap_valid_q <= 1'b1;
          cap_addr_q  <= addr;
          // addr holds at 255 rather than wrapping; the last datum is caught in drain
          if (addr == 8'd255) state_q <= StDrain;
          else                addr    <= addr + 8'd1;
        end
        StDrain: begin
          seen_q      <= seen_d;
          xor_q       <= xor_d;
          dup_q       <= dup_d;
          found_q     <= found_d;
          bad_q       <= bad_d;
          cap_valid_q <= 1'b0;
          is_perm     <= !dup_d;
          is_ident    <= !found_d;
          bad_addr    <= bad_d;
          xor_sum     <= xor_d;
          res_valid   <= 1'b1;
          rdy         <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_s_check.sv
// Self-checking bench for s_check: table of memory images plus hand-written
// corner sequences, with expected results queued in a scoreboard.
module tb_s_check;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       rdy, wren, res_valid, is_ident, is_perm;
  logic [7:0] addr, rddata, bad_addr, xor_sum;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  // Synchronous-read S memory model.
  always @(posedge clk) rddata <= mem[addr];

  s_check dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .addr(addr), .wren(wren),
    .rddata(rddata), .res_valid(res_valid), .is_ident(is_ident), .is_perm(is_perm),
    .bad_addr(bad_addr), .xor_sum(xor_sum)
  );

  typedef struct {
    int         kind;
    logic       ident;
    logic       perm;
    logic [7:0] bad;
    logic [7:0] xs;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // 0 identity, 1 swap 3/7, 2 dup 0x55, 3 reversed, 4 S[255]=0
  task automatic load(input int kind);
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    case (kind)
      1: begin mem[3] = 8'd7; mem[7] = 8'd3; end
      2: begin mem[10] = 8'h55; mem[20] = 8'h55; mem[8'h55] = 8'h0A; end
      3: for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
      4: mem[255] = 8'h00;
      default: ;
    endcase
  endtask

  task automatic cmp_results(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_res_valid"}, res_valid, 1'b1);
    chk({tag, "_is_ident"}, is_ident, e.ident);
    chk({tag, "_is_perm"}, is_perm, e.perm);
    chk({tag, "_bad_addr"}, bad_addr, e.bad);
    chk({tag, "_xor_sum"}, xor_sum, e.xs);
  endtask

  // Accept en, follow the scan, check addr sequence and 257-cycle latency.
  task automatic run_scan(input string tag, input bit repulse);
    int cyc, addr_errs, exp_a;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    cyc = 0;
    addr_errs = 0;
    while (!rdy && cyc < 400) begin
      exp_a = (cyc > 255) ? 255 : cyc;
      if (addr !== exp_a[7:0]) addr_errs++;
      if (wren !== 1'b0) addr_errs++;
      en = repulse && (cyc == 5 || cyc == 100);
      @(posedge clk); #1;
      cyc++;
    end
    en = 1'b0;
    chk({tag, "_addr_seq_errs"}, addr_errs, 0);
    chk({tag, "_latency"}, cyc, 257);
    if (rdy) cmp_results(tag);
  endtask

  initial begin
    int last, nr, w;
    vecs[0] = '{kind: 0, ident: 1'b1, perm: 1'b1, bad: 8'h00, xs: 8'h00};
    vecs[1] = '{kind: 1, ident: 1'b0, perm: 1'b1, bad: 8'h03, xs: 8'h00};
    vecs[2] = '{kind: 2, ident: 1'b0, perm: 1'b0, bad: 8'h0A, xs: 8'h41};
    vecs[3] = '{kind: 3, ident: 1'b0, perm: 1'b1, bad: 8'h00, xs: 8'h00};
    vecs[4] = '{kind: 4, ident: 1'b0, perm: 1'b0, bad: 8'hFF, xs: 8'hFF};

    rst = 1'b1;
    en  = 1'b0;
    load(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rdy", rdy, 1'b1);
    chk("reset_addr", addr, 8'd0);
    chk("reset_wren", wren, 1'b0);
    chk("reset_res_valid", res_valid, 1'b0);
    chk("reset_is_ident", is_ident, 1'b0);
    chk("reset_is_perm", is_perm, 1'b0);
    chk("reset_bad_addr", bad_addr, 8'd0);
    chk("reset_xor_sum", xor_sum, 8'd0);

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].kind);
      sb.push_back(vecs[v]);
      run_scan($sformatf("vec%0d", v), 1'b0);
    end

    // Results hold while idle.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_bad_addr", bad_addr, 8'hFF);
    chk("hold_rdy", rdy, 1'b1);

    // en re-pulsed mid-scan is ignored.
    load(1);
    sb.push_back(vecs[1]);
    run_scan("repulse", 1'b1);
    @(posedge clk); #1;
    chk("repulse_idle_after", rdy, 1'b1);

    // Reset at cycle 100, with en also high on the reset edge.
    load(0);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("midscan_busy", rdy, 1'b0);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b0;
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_addr", addr, 8'd0);
    chk("rst_is_ident", is_ident, 1'b0);
    @(posedge clk); #1;
    chk("rst_en_ignored", rdy, 1'b1);
    sb.push_back(vecs[0]);
    run_scan("after_rst", 1'b0);

    // en held high: rdy pulses for one cycle every 258 cycles.
    load(0);
    for (int i = 0; i < 3; i++) sb.push_back(vecs[0]);
    en = 1'b1;
    @(posedge clk); #1;
    last = 0;
    nr = 0;
    for (int c = 1; c <= 775; c++) begin
      @(posedge clk); #1;
      if (rdy) begin
        chk($sformatf("held_interval%0d", nr), c - last, (nr == 0) ? 257 : 258);
        cmp_results($sformatf("held%0d", nr));
        last = c;
        nr++;
      end
    end
    en = 1'b0;
    chk("held_scan_count", nr, 3);
    w = 0;
    while (!rdy && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    chk("held_final_drain", rdy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
